// File: rtl/ram_arb_pkg.sv
// Shared types for the two-host RAM port arbiter.
// Host identifiers, request/response bundles and the word size of the RAM window.
package ram_arb_pkg;

    typedef enum logic {
        HOST0 = 1'b0,
        HOST1 = 1'b1
    } host_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    localparam int unsigned WordBytes = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way request arbiter: fixed priority (h0 wins) by default, or round-robin
// when RAM_ARB_ROUND_ROBIN_EN is defined.
module arb_rr2
    import ram_arb_pkg::*;
(
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic       clk_i,
    input  logic       rst_ni,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    host_e ptr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr_q == HOST1) ? 2'b10 : 2'b01;
        end
    end

    // The pointer only advances on contention, so a lone requester never steals a turn.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= HOST0;
        end else if (req == 2'b11) begin
            ptr_q <= (ptr_q == HOST0) ? HOST1 : HOST0;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/ram_port_arb.sv
// Shares one single-cycle RAM port between two hosts with address window decode.
// Arbitration mode selected by RAM_ARB_ROUND_ROBIN_EN (undefined: h0 fixed priority).
module ram_port_arb
    import ram_arb_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        h0_req_i,
    input  logic        h0_we_i,
    input  logic [3:0]  h0_be_i,
    input  logic [31:0] h0_addr_i,
    input  logic [31:0] h0_wdata_i,
    output logic        h0_gnt_o,
    output logic        h0_rvalid_o,
    output logic [31:0] h0_rdata_o,
    output logic        h0_err_o,

    input  logic        h1_req_i,
    input  logic        h1_we_i,
    input  logic [3:0]  h1_be_i,
    input  logic [31:0] h1_addr_i,
    input  logic [31:0] h1_wdata_i,
    output logic        h1_gnt_o,
    output logic        h1_rvalid_o,
    output logic [31:0] h1_rdata_o,
    output logic        h1_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    input  logic        ram_rvalid_i
);

    localparam logic [32:0] WinBytes = 33'(Depth) * 33'(WordBytes);

    req_t        h0_req, h1_req, sel_req;
    host_e       sel_host;
    logic [1:0]  arb_gnt, gnt;
    logic        any_gnt, in_range;
    logic [31:0] offset;

    logic        resp_valid_q, resp_err_q, resp_we_q;
    host_e       resp_owner_q;
    resp_t       resp;

    assign h0_req = '{we: h0_we_i, be: h0_be_i, addr: h0_addr_i, wdata: h0_wdata_i};
    assign h1_req = '{we: h1_we_i, be: h1_be_i, addr: h1_addr_i, wdata: h1_wdata_i};

    arb_rr2 u_arb (
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
`endif
        .req    ({h1_req_i, h0_req_i}),
        .gnt    (arb_gnt)
    );

    // Grants are forced low during reset so nothing escapes while the hosts still request.
    assign gnt      = arb_gnt & {2{rst_ni}};
    assign any_gnt  = |gnt;
    assign h0_gnt_o = gnt[0];
    assign h1_gnt_o = gnt[1];
    assign sel_host = gnt[1] ? HOST1 : HOST0;
    assign sel_req  = gnt[1] ? h1_req : h0_req;

    assign offset   = sel_req.addr - BaseAddr;
    assign in_range = (sel_req.addr >= BaseAddr) && ({1'b0, offset} < WinBytes);

    assign ram_req_o   = any_gnt & in_range;
    assign ram_we_o    = sel_req.we;
    assign ram_be_o    = sel_req.be;
    assign ram_addr_o  = offset;
    assign ram_wdata_o = sel_req.wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= HOST0;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= any_gnt;
            if (any_gnt) begin
                resp_owner_q <= sel_host;
                resp_err_q   <= ~in_range;
                resp_we_q    <= sel_req.we;
            end
        end
    end

    // Only in-range reads carry RAM data; errors and write acknowledges return zero.
    always_comb begin
        resp.rvalid = resp_valid_q;
        resp.err    = resp_valid_q & resp_err_q;
        resp.rdata  = 32'h0;
        if (resp_valid_q && !resp_err_q && !resp_we_q && ram_rvalid_i) begin
            resp.rdata = ram_rdata_i;
        end
    end

    assign h0_rvalid_o = resp.rvalid & (resp_owner_q == HOST0);
    assign h0_err_o    = resp.err    & (resp_owner_q == HOST0);
    assign h0_rdata_o  = (resp_owner_q == HOST0) ? resp.rdata : 32'h0;
    assign h1_rvalid_o = resp.rvalid & (resp_owner_q == HOST1);
    assign h1_err_o    = resp.err    & (resp_owner_q == HOST1);
    assign h1_rdata_o  = (resp_owner_q == HOST1) ? resp.rdata : 32'h0;

endmodule

// File: tb/tb_ram_port_arb.sv
// Scoreboard bench for ram_port_arb with a byte-enabled RAM model behind the port.
module tb_ram_port_arb;

    localparam int unsigned Depth = 128;
    localparam int unsigned Aw    = $clog2(Depth);
    localparam logic [31:0] Base  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        h0_req, h0_we, h0_gnt, h0_rvalid, h0_err;
    logic [3:0]  h0_be;
    logic [31:0] h0_addr, h0_wdata, h0_rdata;
    logic        h1_req, h1_we, h1_gnt, h1_rvalid, h1_err;
    logic [3:0]  h1_be;
    logic [31:0] h1_addr, h1_wdata, h1_rdata;
    logic        ram_req, ram_we, ram_rvalid;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    typedef struct {
        int          host;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t expq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    logic [31:0] mem [Depth];

    always #5 clk = ~clk;

    ram_port_arb #(.Depth(Depth), .BaseAddr(Base)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .h0_req_i    (h0_req),
        .h0_we_i     (h0_we),
        .h0_be_i     (h0_be),
        .h0_addr_i   (h0_addr),
        .h0_wdata_i  (h0_wdata),
        .h0_gnt_o    (h0_gnt),
        .h0_rvalid_o (h0_rvalid),
        .h0_rdata_o  (h0_rdata),
        .h0_err_o    (h0_err),
        .h1_req_i    (h1_req),
        .h1_we_i     (h1_we),
        .h1_be_i     (h1_be),
        .h1_addr_i   (h1_addr),
        .h1_wdata_i  (h1_wdata),
        .h1_gnt_o    (h1_gnt),
        .h1_rvalid_o (h1_rvalid),
        .h1_rdata_o  (h1_rdata),
        .h1_err_o    (h1_err),
        .ram_req_o   (ram_req),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata),
        .ram_rvalid_i(ram_rvalid)
    );

    // RAM model: writes land at the request edge, read data one cycle later.
    always @(posedge clk) begin
        ram_rvalid <= ram_req;
        ram_rdata  <= 32'h0;
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[Aw+1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr[Aw+1:2]];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int host, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (host == 0) begin
            h0_req = req; h0_we = we; h0_be = be; h0_addr = addr; h0_wdata = wdata;
        end else begin
            h1_req = req; h1_we = we; h1_be = be; h1_addr = addr; h1_wdata = wdata;
        end
    endtask

    // Monitor: every response the DUT presents is matched against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && (h0_rvalid || h1_rvalid)) begin
            if (expq.size() == 0) begin
                check_output("unexpected_rvalid", {30'h0, h1_rvalid, h0_rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check_output("resp_owner", {30'h0, h1_rvalid, h0_rvalid}, (e.host == 1) ? 32'h2 : 32'h1);
                if (e.host == 1) begin
                    check_output("resp_err_h1", {31'h0, h1_err}, {31'h0, e.err});
                    check_output("resp_rdata_h1", h1_rdata, e.rdata);
                    check_output("nonowner_rdata_h0", h0_rdata, 32'h0);
                end else begin
                    check_output("resp_err_h0", {31'h0, h0_err}, {31'h0, e.err});
                    check_output("resp_rdata_h0", h0_rdata, e.rdata);
                    check_output("nonowner_rdata_h1", h1_rdata, 32'h0);
                end
            end
        end
    end

    task automatic apply_stimulus(input int host, input logic we, input logic [3:0] be,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic exp_err, input logic [31:0] exp_rdata);
        bit   got = 0;
        exp_t e;
        @(posedge clk); #1;
        drive(host, 1'b1, we, be, addr, wdata);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((host == 0) ? h0_gnt : h1_gnt) begin
                got = 1;
                check_output("ram_req", {31'h0, ram_req}, {31'h0, ~exp_err});
                if (!exp_err) begin
                    check_output("ram_addr", ram_addr, addr - Base);
                    check_output("ram_we", {31'h0, ram_we}, {31'h0, we});
                    if (we) begin
                        check_output("ram_wdata", ram_wdata, wdata);
                        check_output("ram_be", {28'h0, ram_be}, {28'h0, be});
                    end
                end
                e.host  = host;
                e.err   = exp_err;
                e.rdata = (exp_err || we) ? 32'h0 : exp_rdata;
                expq.push_back(e);
                break;
            end
        end
        @(posedge clk); #1;
        drive(host, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (got) begin
            @(negedge clk);
            check_output("rvalid_latency", {31'h0, (host == 0) ? h0_rvalid : h1_rvalid}, 32'h1);
        end else begin
            check_output("gnt_timeout", 32'h0, 32'h1);
        end
    endtask

    task automatic check_quiet(input string name);
        check_output(name, {26'h0, h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, h0_err, h1_err}, 32'h0);
        check_output({name, "_ramreq"}, {31'h0, ram_req}, 32'h0);
        check_output({name, "_rdata"}, h0_rdata | h1_rdata, 32'h0);
    endtask

    initial begin
        exp_t e;
        logic [1:0] exp_g;
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 4'hF, Base, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, Base, 32'h0);
        repeat (2) @(negedge clk);
        check_quiet("reset_outputs");
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write then read back, out-of-range both sides, partial and empty byte enables.
        apply_stimulus(0, 1'b1, 4'hF, Base + 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        apply_stimulus(0, 1'b0, 4'hF, Base + 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        apply_stimulus(1, 1'b0, 4'hF, Base + 4 * Depth, 32'h0, 1'b1, 32'h0);
        apply_stimulus(0, 1'b0, 4'hF, Base - 32'h4, 32'h0, 1'b1, 32'h0);
        apply_stimulus(1, 1'b1, 4'hF, Base + 32'h20, 32'h11223344, 1'b0, 32'h0);
        apply_stimulus(0, 1'b1, 4'b0010, Base + 32'h20, 32'h0000AB00, 1'b0, 32'h0);
        apply_stimulus(1, 1'b0, 4'hF, Base + 32'h20, 32'h0, 1'b0, 32'h1122AB44);
        apply_stimulus(0, 1'b0, 4'hF, Base + 32'h23, 32'h0, 1'b0, 32'h1122AB44);
        apply_stimulus(1, 1'b1, 4'h0, Base + 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0);
        apply_stimulus(1, 1'b0, 4'hF, Base + 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        apply_stimulus(1, 1'b1, 4'hF, Base + 4 * Depth - 4, 32'hCAFEF00D, 1'b0, 32'h0);

        // Both hosts hold requests for four cycles.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'hF, Base + 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, Base + 4 * Depth - 4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            check_output("contend_gnt", {30'h0, h1_gnt, h0_gnt}, {30'h0, exp_g});
            e.host  = exp_g[1] ? 1 : 0;
            e.err   = 1'b0;
            e.rdata = exp_g[1] ? 32'hCAFEF00D : 32'hDEADBEEF;
            expq.push_back(e);
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);

        // Reset lands in the cycle after a grant; that response must vanish.
        #1;
        drive(0, 1'b1, 1'b0, 4'hF, Base + 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, Base + 32'h20, 32'h0);
        @(negedge clk);
        check_output("prereset_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        expq.delete();
        @(negedge clk);
        check_quiet("midreset_outputs");
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("postreset_quiet");
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 4'hF, Base + 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 4'hF, Base + 32'h20, 32'h0);
        @(negedge clk);
        check_output("postreset_contend_gnt", {30'h0, h1_gnt, h0_gnt}, 32'h1);
        e.host  = 0;
        e.err   = 1'b0;
        e.rdata = 32'hDEADBEEF;
        expq.push_back(e);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        for (int c = 0; c < 10 && expq.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        check_output("scoreboard_drain", expq.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
